// File: rtl/rnd_pkg.sv
// rnd_pkg: shared definitions for the bounded random-number stage.
//   - FSM state encoding used by rnd_range
//   - clog2 helper for sizing the retry and spacing counters
package rnd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAW = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Ceiling log2; clog2(1) = 0, clog2(9) = 4.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rnd_mask.sv
// rnd_mask: combinational bit-smear of (limit - 1).
// Produces the smallest 2^k - 1 that is >= limit - 1, so masked LFSR
// candidates land in [0, 2*limit - 1] and rejection stays below 50%.
//   limit : in,  W  exclusive upper bound
//   mask  : out, W  smeared mask
module rnd_mask #(
  parameter int W = 16
) (
  input  logic [W-1:0] limit,
  output logic [W-1:0] mask
);

  logic [W-1:0] lim_m1;

  assign lim_m1 = limit - W'(1);

  // Doubling shift distances copy the leading one into every lower bit.
  always_comb begin
    mask = lim_m1;
    for (int s = 1; s < W; s = s * 2) begin
      mask = mask | (mask >> s);
    end
  end

endmodule

// File: rtl/rnd_range.sv
// rnd_range: returns a uniform value in [0, limit-1] from a free-running
// LFSR word using mask-and-reject sampling, with a biased fallback
// (cand - limit) after MAX_TRIES rejections. Draws are SPACING cycles
// apart so each candidate uses LFSR bits not seen by the previous one.
//
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | spacing between draws after a rejection
//   DRAW  | sample rnd_in, accept or reject the candidate
//   DONE  | result held until out_ready
//
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   rnd_in [N]            : LFSR word, bits [W-1:0] used
//   req_valid/req_ready   : request handshake, req_limit [W] bound
//   out_valid/out_ready   : result handshake
//   out_value [W]         : result
//   out_biased            : result came from the fallback path
//   out_err               : request had limit == 0
module rnd_range
  import rnd_pkg::*;
#(
  parameter int N         = 64,
  parameter int W         = 16,
  parameter int MAX_TRIES = 8,
  parameter int SPACING   = W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] rnd_in,
  input  logic         req_valid,
  input  logic [W-1:0] req_limit,
  output logic         req_ready,
  output logic         out_valid,
  output logic [W-1:0] out_value,
  output logic         out_biased,
  output logic         out_err,
  input  logic         out_ready
);

  localparam int TW = clog2(MAX_TRIES + 1);
  localparam int SW = (SPACING > 1) ? clog2(SPACING) : 1;
  localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES);
  localparam logic [SW-1:0] SPC_LOAD   = SW'(SPACING - 1);

  logic [1:0]    state;
  logic [W-1:0]  limit_q;
  logic [W-1:0]  mask_q;
  logic [W-1:0]  mask_d;
  logic [W-1:0]  cand;
  logic [TW-1:0] tries;
  logic [TW-1:0] tries_inc;
  logic [SW-1:0] spc_cnt;
  logic          unused_rnd;

  rnd_mask #(.W(W)) u_mask (
    .limit (req_limit),
    .mask  (mask_d)
  );

  assign cand       = rnd_in[W-1:0] & mask_q;
  assign tries_inc  = tries + TW'(1);
  assign req_ready  = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  // Upper LFSR bits are deliberately ignored.
  assign unused_rnd = ^rnd_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      limit_q    <= '0;
      mask_q     <= '0;
      tries      <= '0;
      spc_cnt    <= '0;
      out_value  <= '0;
      out_biased <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            limit_q <= req_limit;
            mask_q  <= mask_d;
            tries   <= '0;
            if (req_limit == '0) begin
              out_value <= '0;
              out_err   <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_DRAW;
            end
          end
        end
        ST_DRAW: begin
          if (cand < limit_q) begin
            out_value  <= cand;
            out_biased <= 1'b0;
            state      <= ST_DONE;
          end else begin
            tries <= tries_inc;
            if (tries_inc == TRIES_LAST) begin
              // mask < 2*limit, so cand - limit is always in range.
              out_value  <= cand - limit_q;
              out_biased <= 1'b1;
              state      <= ST_DONE;
            end else if (SPACING == 1) begin
              state <= ST_DRAW;
            end else begin
              spc_cnt <= SPC_LOAD;
              state   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Leaves on the count that reaches 0, so the next draw is
          // exactly SPACING cycles after the previous one.
          spc_cnt <= spc_cnt - SW'(1);
          if (spc_cnt == SW'(1)) begin
            state <= ST_DRAW;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_biased <= 1'b0;
            out_err    <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rnd_range.sv
// tb_rnd_range: directed and LFSR-driven checks of rnd_range against a
// behavioural model of mask-and-reject sampling.
module tb_rnd_range;

  localparam int N         = 64;
  localparam int W         = 16;
  localparam int MAX_TRIES = 8;
  localparam int SPACING   = 16;
  localparam int TMO       = 200;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] rnd_in;
  logic         req_valid;
  logic [W-1:0] req_limit;
  logic         req_ready;
  logic         out_valid;
  logic [W-1:0] out_value;
  logic         out_biased;
  logic         out_err;
  logic         out_ready;

  logic [N-1:0] rnd_drv;
  logic [N-1:0] lfsr;
  logic         lfsr_en;
  logic [15:0]  words [0:TMO+1];

  int checks;
  int errors;

  rnd_range #(.N(N), .W(W), .MAX_TRIES(MAX_TRIES), .SPACING(SPACING)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rnd_in     (rnd_in),
    .req_valid  (req_valid),
    .req_limit  (req_limit),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_value  (out_value),
    .out_biased (out_biased),
    .out_err    (out_err),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rnd_in = lfsr_en ? lfsr : rnd_drv;

  always @(negedge clk) begin
    if (lfsr_en) lfsr = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: draws happen at edges 1, 1+S, 1+2S, ... after acceptance;
  // result visible one cycle after the deciding draw.
  function automatic void model(input int lim, output int v, output int b,
                                output int e, output int lat);
    int m;
    int c;
    v = 0; b = 0; e = 0; lat = 1;
    if (lim == 0) begin
      e = 1;
      return;
    end
    m = 0;
    while (m < lim - 1) m = m * 2 + 1;
    c = 0;
    for (int j = 0; j < MAX_TRIES; j++) begin
      c = int'(words[1 + j * SPACING]) & m;
      if (c < lim) begin
        v = c;
        lat = 2 + j * SPACING;
        return;
      end
    end
    v = c - lim;
    b = 1;
    lat = 2 + (MAX_TRIES - 1) * SPACING;
  endfunction

  // Called and returns at a negedge with the DUT idle.
  task automatic do_req(input logic [15:0] lim, input bit drive,
                        input logic [15:0] r0, input logic [15:0] r1,
                        input int stall, output logic [15:0] v_o,
                        output logic b_o, output logic e_o, output int lat_o);
    int k;
    int ev, eb, ee, el;
    if (drive) begin
      rnd_drv = {$urandom(), $urandom()};
      rnd_drv[15:0] = r0;
    end
    out_ready = (stall == 0);
    req_valid = 1'b1;
    req_limit = lim;
    chk("req_ready_idle", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_limit = 16'($urandom());
    lat_o = 0;
    v_o = '0; b_o = 1'b0; e_o = 1'b0;
    @(negedge clk);
    if (out_valid) lat_o = 1;
    k = 0;
    while (lat_o == 0 && k < TMO) begin
      chk("busy_req_ready", 64'(req_ready), 64'(0));
      @(posedge clk);
      k++;
      words[k] = rnd_in[15:0];
      @(negedge clk);
      if (drive && k == 1) rnd_drv[15:0] = r1;
      if (out_valid) lat_o = k + 1;
    end
    if (lat_o == 0) begin
      chk("timeout_out_valid", 64'(out_valid), 64'(1));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      return;
    end
    v_o = out_value; b_o = out_biased; e_o = out_err;
    model(int'(lim), ev, eb, ee, el);
    chk("latency", 64'(lat_o), 64'(el));
    chk("value", 64'(out_value), 64'(ev));
    chk("biased", 64'(out_biased), 64'(eb));
    chk("err", 64'(out_err), 64'(ee));
    if (lim != 0) chk("in_range", 64'(out_value < lim), 64'(1));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_value", 64'(out_value), 64'(v_o));
      chk("hold_biased", 64'(out_biased), 64'(b_o));
      chk("hold_err", 64'(out_err), 64'(e_o));
      chk("hold_req_ready", 64'(req_ready), 64'(0));
    end
    out_ready = 1'b1;
    chk("take_req_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_valid", 64'(out_valid), 64'(0));
    chk("after_req_ready", 64'(req_ready), 64'(1));
    chk("after_biased", 64'(out_biased), 64'(0));
    chk("after_err", 64'(out_err), 64'(0));
  endtask

  initial begin
    logic [15:0] v;
    logic        b;
    logic        e;
    int          lat;
    int          cnt6 [0:5];
    int          n6;
    real         chi;
    real         ex;
    logic [15:0] lim;

    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_limit = '0;
    out_ready = 1'b0;
    lfsr_en = 1'b0;
    lfsr = 64'hACE1_2468_9BDF_1357;
    rnd_drv = '0;
    for (int i = 0; i < 6; i++) cnt6[i] = 0;
    n6 = 0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_out_value", 64'(out_value), 64'(0));
    chk("rst_out_biased", 64'(out_biased), 64'(0));
    chk("rst_out_err", 64'(out_err), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    do_req(16'd6, 1'b1, 16'h0003, 16'h0003, 0, v, b, e, lat);
    chk("t1_value", 64'(v), 64'(3));
    chk("t1_biased", 64'(b), 64'(0));
    chk("t1_lat", 64'(lat), 64'(2));

    do_req(16'd6, 1'b1, 16'h0007, 16'h0005, 0, v, b, e, lat);
    chk("t2_value", 64'(v), 64'(5));
    chk("t2_lat", 64'(lat), 64'(2 + SPACING));

    do_req(16'd5, 1'b1, 16'h0007, 16'h0007, 0, v, b, e, lat);
    chk("t3_value", 64'(v), 64'(2));
    chk("t3_biased", 64'(b), 64'(1));
    chk("t3_lat", 64'(lat), 64'(2 + 7 * SPACING));

    do_req(16'd0, 1'b1, 16'($urandom()), 16'($urandom()), 0, v, b, e, lat);
    chk("t4_err", 64'(e), 64'(1));
    chk("t4_value", 64'(v), 64'(0));
    chk("t4_lat", 64'(lat), 64'(1));

    do_req(16'd1, 1'b1, 16'($urandom()), 16'($urandom()), 0, v, b, e, lat);
    chk("t5_value", 64'(v), 64'(0));
    chk("t5_lat", 64'(lat), 64'(2));

    do_req(16'd9, 1'b1, 16'h0008, 16'h0001, 10, v, b, e, lat);
    chk("t6_value", 64'(v), 64'(8));
    chk("t6_lat", 64'(lat), 64'(2));

    do_req(16'hFFFF, 1'b1, 16'hFFFF, 16'h1234, 0, v, b, e, lat);
    chk("t7_value", 64'(v), 64'(16'h1234));
    chk("t7_lat", 64'(lat), 64'(2 + SPACING));

    // Reset while waiting between draws drops the request.
    rnd_drv[15:0] = 16'h0007;
    req_valid = 1'b1;
    req_limit = 16'd6;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstw_out_valid", 64'(out_valid), 64'(0));
    chk("rstw_req_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    reset_n = 1'b1;
    rnd_drv[15:0] = 16'h0002;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rstw_no_valid", 64'(out_valid), 64'(0));
      chk("rstw_idle", 64'(req_ready), 64'(1));
    end

    do_req(16'd6, 1'b1, 16'h0004, 16'h0004, 0, v, b, e, lat);
    chk("t8_value", 64'(v), 64'(4));

    lfsr_en = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      do_req(16'd6, 1'b0, 16'h0, 16'h0, 0, v, b, e, lat);
      if (v < 6) cnt6[v] = cnt6[v] + 1;
      n6++;
    end
    ex = real'(n6) / 6.0;
    chi = 0.0;
    for (int i = 0; i < 6; i++) chi = chi + (real'(cnt6[i]) - ex) * (real'(cnt6[i]) - ex) / ex;
    chk("chi_square_lim6", 64'(chi < 30.0), 64'(1));

    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0: lim = 16'($urandom_range(1, 65535));
        1: lim = 16'($urandom_range(0, 40));
        2: lim = 16'($urandom_range(1, 16));
        default: lim = 16'(1 << $urandom_range(0, 15));
      endcase
      do_req(lim, 1'b0, 16'h0, 16'h0, int'($urandom_range(0, 3)), v, b, e, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
